// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the per-frame update scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    FIN
  } sched_state_t;

  localparam int unsigned CL_INPUT = 0;
  localparam int unsigned CL_PHYS  = 1;
  localparam int unsigned CL_COLL  = 2;
  localparam int unsigned CL_SCORE = 3;

  localparam int unsigned BC_W = 15;

endpackage

// File: rtl/cycle_budget_timer.sv
// Per-frame cycle budget counter; flags expiry at WINDOW_CYCLES-1.
module cycle_budget_timer
  import frame_sched_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 24000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [BC_W-1:0] bc;

  assign expired = (bc == BC_W'(WINDOW_CYCLES - 1));

  // Holds at the expiry value so a client started on the expiry cycle
  // still sees the budget as exhausted in its first WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bc <= '0;
    end else if (enable && !expired) begin
      bc <= bc + 1'b1;
    end
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// Launches the game-state update clients in order during vertical blanking,
// under a per-frame cycle budget, with frame-rate division and pause.
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NCLIENT       = 4,
  parameter int unsigned WINDOW_CYCLES = 24000,
  parameter int unsigned FRAME_DIV     = 1
) (
  input  logic               pixel_clock,
  input  logic               rst,
  input  logic               Vsync,
  input  logic               pause,
  input  logic               ovf_clr,
  output logic [NCLIENT-1:0] start,
  input  logic [NCLIENT-1:0] done,
  output logic               busy,
  output logic               overrun,
  output logic [15:0]        frame_count
);

  localparam int unsigned IDX_W = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCLIENT - 1);

  sched_state_t     state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             vsync_q;
  logic             fev;
  logic             launch;
  logic             abort;
  logic             expired;
  logic [7:0]       div_cnt;

  assign fev    = vsync_q && !Vsync;
  assign launch = fev && (state == IDLE) && !pause && (div_cnt == '0);

  cycle_budget_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_budget (
    .clk    (pixel_clock),
    .rst    (rst),
    .clear  (launch),
    .enable ((state == START) || (state == WAIT)),
    .expired(expired)
  );

  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_n = START;
          idx_n   = '0;
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (done[idx]) begin
          if (idx == LAST_IDX) begin
            state_n = FIN;
          end else begin
            state_n = START;
            idx_n   = idx + 1'b1;
          end
        end else if (expired) begin
          state_n = FIN;
          abort   = 1'b1;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // start/busy are registered from the next state so they line up with it.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      vsync_q     <= 1'b1;
      div_cnt     <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      start       <= '0;
      busy        <= 1'b0;
    end else begin
      vsync_q <= Vsync;
      if (fev) begin
        frame_count <= frame_count + 16'd1;
      end
      if (fev && (state == IDLE) && !pause) begin
        div_cnt <= (div_cnt == 8'(FRAME_DIV - 1)) ? '0 : div_cnt + 8'd1;
      end
      if (abort || (fev && (state != IDLE))) begin
        overrun <= 1'b1;
      end else if (ovf_clr) begin
        overrun <= 1'b0;
      end
      start <= '0;
      if (state_n == START) begin
        start[idx_n] <= 1'b1;
      end
      busy <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Frame-level random bench: expected start timing, busy fall, frame count and
// overrun are computed from handshake arithmetic per frame.
module tb_frame_update_scheduler;

  localparam int NC  = 4;
  localparam int W   = 100;
  localparam int FD  = 2;
  localparam int WIN = 120;

  logic          pixel_clock = 1'b0;
  logic          rst         = 1'b1;
  logic          Vsync       = 1'b1;
  logic          pause       = 1'b0;
  logic          ovf_clr     = 1'b0;
  logic [NC-1:0] done        = '0;
  logic [NC-1:0] start;
  logic          busy;
  logic          overrun;
  logic [15:0]   frame_count;

  frame_update_scheduler #(
    .NCLIENT      (NC),
    .WINDOW_CYCLES(W),
    .FRAME_DIV    (FD)
  ) dut (
    .pixel_clock(pixel_clock),
    .rst        (rst),
    .Vsync      (Vsync),
    .pause      (pause),
    .ovf_clr    (ovf_clr),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  always #20 pixel_clock = ~pixel_clock;

  typedef struct {
    int         c;
    logic [3:0] v;
  } ev_t;

  int   cyc = 0;
  ev_t  act_q[$];
  ev_t  exp_q[$];
  int   due[NC] = '{-1, -1, -1, -1};
  int   dly[NC] = '{0, 0, 0, 0};
  logic prev_busy = 1'b0;
  int   busy_fall = -1;

  int   n_chk = 0;
  int   n_bad = 0;

  int   m_fc  = 0;
  int   m_div = 0;
  bit   m_ovf = 1'b0;

  always @(posedge pixel_clock) cyc++;

  // Observe start pulses, arm the matching client's reply, track busy falling.
  always @(negedge pixel_clock) begin
    if (start != '0) begin
      act_q.push_back('{cyc, start});
      for (int i = 0; i < NC; i++)
        if (start[i] === 1'b1 && dly[i] > 0) due[i] = cyc + dly[i];
    end
    if (prev_busy && busy === 1'b0) busy_fall = cyc;
    prev_busy = busy;
  end

  always @(posedge pixel_clock) begin
    #1;
    for (int i = 0; i < NC; i++) done[i] = (due[i] == cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  // Expected start schedule from the handshake rules; returns busy-fall cycle.
  task automatic model_seq(input int t, output bit aborted, output int endc);
    int s, a, d;
    s = t + 1;
    aborted = 1'b0;
    endc = -1;
    for (int i = 0; i < NC; i++) begin
      exp_q.push_back('{s, 4'(1 << i)});
      a = (s + 1 > t + W) ? s + 1 : t + W;
      d = (dly[i] == 0) ? 32'h7fff_ffff : s + dly[i];
      if (d > a) begin
        aborted = 1'b1;
        endc = a + 2;
        return;
      end
      s = d + 1;
    end
    endc = s + 1;
  endtask

  task automatic run_frame(input bit p, input int d0, input int d1, input int d2,
                           input int d3, input bit sec, input bit clr_same,
                           input bit clr_after);
    int t, endc;
    bit launch, ab;
    dly = '{d0, d1, d2, d3};
    due = '{-1, -1, -1, -1};
    act_q.delete();
    exp_q.delete();
    busy_fall = -1;
    endc = -1;
    pause = p;
    Vsync = 1'b0;
    t = cyc;
    m_fc = (m_fc + 1) & 16'hffff;
    launch = !p && (m_div == 0);
    if (!p) m_div = (m_div + 1) % FD;
    if (launch) begin
      model_seq(t, ab, endc);
      if (ab) m_ovf = 1'b1;
    end
    repeat (3) tick();
    Vsync = 1'b1;
    if (sec && launch) begin
      repeat (3) tick();
      Vsync = 1'b0;
      ovf_clr = clr_same;
      m_fc = (m_fc + 1) & 16'hffff;
      m_ovf = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tick();
      Vsync = 1'b1;
    end
    while (cyc < t + WIN) tick();
    chk("n_starts", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk("start_cycle", act_q[i].c - t, exp_q[i].c - t);
      chk("start_value", act_q[i].v, exp_q[i].v);
    end
    chk("busy_fall", (busy_fall < 0) ? -1 : busy_fall - t, (endc < 0) ? -1 : endc - t);
    chk("busy_idle", busy, 0);
    chk("frame_count", frame_count, m_fc);
    chk("overrun", overrun, m_ovf);
    if (clr_after) begin
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
      tick();
      chk("overrun_clr", overrun, m_ovf);
    end
    pause = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_count", frame_count, 0);
    repeat (4) tick();
    chk("no_spurious_fev", frame_count, 0);

    // Nominal 10-cycle replies, idle divided frame, missing client, budget edges,
    // and a second frame edge mid-sequence with a same-cycle clear.
    run_frame(0, 10, 10, 10, 10, 0, 0, 0);
    run_frame(0, 10, 10, 10, 10, 0, 0, 0);
    run_frame(0, 10, 10, 0, 5, 0, 0, 1);
    run_frame(0, 3, 3, 3, 3, 0, 0, 0);
    run_frame(0, 10, 10, 10, 66, 0, 0, 0);
    run_frame(0, 3, 3, 3, 3, 0, 0, 0);
    run_frame(0, 10, 10, 10, 67, 0, 0, 1);
    run_frame(1, 3, 3, 3, 3, 0, 0, 0);
    run_frame(0, 3, 3, 3, 3, 0, 0, 0);
    run_frame(0, 4, 8, 4, 4, 1, 1, 1);

    for (int f = 0; f < 40; f++) begin
      int d[NC];
      for (int i = 0; i < NC; i++)
        d[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 20));
      run_frame($urandom_range(0, 3) == 0, d[0], d[1], d[2], d[3],
                $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0);
    end

    // Reset while client 1 is waiting; its late done must not restart anything.
    if (m_div != 0) run_frame(0, 2, 2, 2, 2, 0, 0, 0);
    dly = '{5, 10, 5, 5};
    due = '{-1, -1, -1, -1};
    Vsync = 1'b0;
    t = cyc;
    repeat (3) tick();
    Vsync = 1'b1;
    while (cyc < t + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    act_q.delete();
    m_fc = 0;
    m_div = 0;
    m_ovf = 1'b0;
    chk("rst_mid_start", start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_frame_count", frame_count, m_fc);
    chk("rst_mid_overrun", overrun, m_ovf);
    repeat (20) tick();
    chk("rst_mid_no_start", act_q.size(), 0);
    chk("rst_mid_busy_late", busy, 0);
    run_frame(0, 3, 5, 7, 9, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
